// File: rtl/cla_pipe_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// default geometry, op encodings, configuration check and the 4-bit lookahead slice.
package cla_pipe_addsub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEG_W_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nstg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic bit cfg_ok(input int width, input int seg_w);
    return (seg_w >= 4) && (seg_w % 4 == 0) && (width >= seg_w) && (width % seg_w == 0);
  endfunction

  typedef struct packed {
    logic [3:0] s;
    logic       g;
    logic       p;
  } cla4_t;

  // Fully expanded 4-bit lookahead: internal carries never ripple, and the
  // group generate/propagate let the caller chain slices without the sum path.
  function automatic cla4_t cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    cla4_t      r;
    p    = x ^ y;
    g    = x & y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    r.s  = p ^ c;
    r.g  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p  = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_seg.sv
// Combinational SEG_W-bit carry-lookahead segment built from 4-bit lookahead slices.
// Exposes the carry out and the carry into the MSB so the caller can derive overflow.
module cla_seg
  import cla_pipe_addsub_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             cm
);

  localparam int NG = SEG_W / 4;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic  cin;
    logic  cout;
    cla4_t r;

    if (g == 0) begin : g_first
      assign cin = ci;
    end else begin : g_next
      assign cin = g_grp[g-1].cout;
    end

    assign r            = cla4(x[4*g +: 4], y[4*g +: 4], cin);
    assign cout         = r.g | (r.p & cin);
    assign s[4*g +: 4]  = r.s;
  end

  assign co = g_grp[NG-1].cout;
  // Sum bit is x^y^carry-in, so the MSB carry-in falls out without a second chain.
  assign cm = s[SEG_W-1] ^ x[SEG_W-1] ^ y[SEG_W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract: one SEG_W segment resolved per stage, full
// valid/ready backpressure, results emerge NSTG cycles after acceptance.
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSTG = nstg(WIDTH, SEG_W);

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = (sub == OP_ADD) ? b : ~b;
  assign c_eff = (sub == OP_SUB) ? ~ci : ci;

  // Each stage register holds a merged word: already-resolved sum segments in
  // the low bits and the still-unconsumed A segments above them.
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * SEG_W;
    localparam int BW = WIDTH - (k + 1) * SEG_W;

    logic             vld_in;
    logic             rdy;
    logic             rdy_dn;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] acc_nxt;
    logic [SEG_W-1:0] b_seg;
    logic [SEG_W-1:0] seg_s;
    logic             c_in;
    logic             seg_co;
    logic             seg_cm;
    logic             vld_p;
    logic             co_p;
    logic [WIDTH-1:0] acc_p;

    if (k == 0) begin : g_src
      assign vld_in = in_valid;
      assign acc_in = a;
      assign b_seg  = b_eff[SEG_W-1:0];
      assign c_in   = c_eff;
    end else begin : g_src
      assign vld_in = g_stg[k-1].vld_p;
      assign acc_in = g_stg[k-1].acc_p;
      assign b_seg  = g_stg[k-1].g_b.b_p[SEG_W-1:0];
      assign c_in   = g_stg[k-1].co_p;
    end

    if (k == NSTG - 1) begin : g_dn_out
      assign rdy_dn = out_ready;
    end else begin : g_dn_stg
      assign rdy_dn = g_stg[k+1].rdy;
    end

    assign rdy = !vld_p || rdy_dn;

    cla_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .x  (acc_in[LO +: SEG_W]),
      .y  (b_seg),
      .ci (c_in),
      .s  (seg_s),
      .co (seg_co),
      .cm (seg_cm)
    );

    always_comb begin
      acc_nxt             = acc_in;
      acc_nxt[LO +: SEG_W] = seg_s;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p <= 1'b0;
      end else if (rdy) begin
        vld_p <= vld_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rdy && vld_in) begin
        acc_p <= acc_nxt;
        co_p  <= seg_co;
      end
    end

    if (BW > 0) begin : g_b
      logic [BW-1:0] b_nxt;
      logic [BW-1:0] b_p;

      if (k == 0) begin : g_bsrc
        assign b_nxt = b_eff[WIDTH-1:SEG_W];
      end else begin : g_bsrc
        assign b_nxt = g_stg[k-1].g_b.b_p[BW+SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk) begin
        if (rdy && vld_in) begin
          b_p <= b_nxt;
        end
      end
    end

    if (k == NSTG - 1) begin : g_ovf
      logic ovf_p;
      always_ff @(posedge clk) begin
        if (rdy && vld_in) begin
          ovf_p <= seg_co ^ seg_cm;
        end
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = seg_cm;
    end
  end

  assign in_ready  = g_stg[0].rdy && !reset;
  assign out_valid = g_stg[NSTG-1].vld_p;

  // Data registers carry no reset; the outputs read as zero whenever no result is held.
  assign s   = g_stg[NSTG-1].acc_p & {WIDTH{out_valid}};
  assign co  = g_stg[NSTG-1].co_p & out_valid;
  assign ovf = g_stg[NSTG-1].g_ovf.ovf_p & out_valid;

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for wide operands; successor to the fixed 8-bit combinational CLA.
- Splits a WIDTH-bit add into WIDTH/SEG_W segments and resolves one segment per pipeline stage.
- Throughput: one operation per clock.
- Valid/ready handshake with backpressure on both sides; sits between operand producers (register file, accumulator control) and result consumers in the datapath.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG_W.
- SEG_W, 8, bits resolved per stage; must be a multiple of 4. Stage count NSTG = WIDTH/SEG_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in (sub=0) / borrow-in (sub=1)
- sub  input  1  0: s=a+b+ci; 1: s=a-b-ci
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- co  output  1  raw carry out of MSB (sub=1: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: out_valid=0, s=0, co=0, ovf=0, all stage valid bits=0. in_ready=0 while reset is high. Reset mid-operation discards every in-flight beat and produces no output for them.
- Accept: a beat transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Operand preprocessing at acceptance:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~ci : ci.
- Stage k (0..NSTG-1):
  - Adds segment k of a and b_eff with the carry from stage k-1 (stage 0 uses c_eff), using a SEG_W-bit lookahead adder.
  - Registers the sum segment, the carry out, and the not-yet-consumed upper operand segments.
  - Lower sum segments already computed ride along (skew/deskew registers), so the final stage holds the full aligned s.
- Latency: exactly NSTG cycles from accept to out_valid with out_ready held high (4 for defaults).
- co: carry out of the final segment.
- ovf: (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
- Handshake, per stage: stage_ready[k] = !stage_valid[k] || stage_ready[k+1]; stage_ready[NSTG] = out_ready.
  - in_ready = stage_ready[0] (when not in reset).
  - All stages advance together when unstalled; a full pipeline with out_ready high sustains one beat per cycle.
  - A stalled stage holds its registers unchanged. Bubbles collapse into empty downstream stages.
- out_valid/s/co/ovf are stable while out_valid && !out_ready (no change until the transfer).
- Simultaneous accept and output in the same cycle on a full pipeline: both occur and occupancy is unchanged.
- Wrap-around is modulo 2^WIDTH; co/ovf report the wrap.
- No combinational path from a/b to s. The only combinational path is out_ready -> in_ready through the stall chain.

Decomposition:
- Shared package/header holds:
  - WIDTH/SEG_W defaults and the NSTG derivation.
  - Op encodings OP_ADD=0, OP_SUB=1.
  - An elaboration check that WIDTH%SEG_W==0 and SEG_W%4==0.
- Sub-module cla_seg: combinational SEG_W-bit CLA, built from the existing 4-bit lookahead slices with group generate/propagate, exposing s, co and the MSB carry-in (for ovf).
- cla_pipe_addsub instantiates NSTG cla_seg instances plus the valid/ready, skew and deskew registers.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, s=0. Assert reset while 3 beats are in flight -> none emerge after release.
- Single add: a=32'hFFFF_FFFF, b=1, ci=0, sub=0 -> exactly 4 cycles later s=0, co=1, ovf=0.
- Signed overflow and subtract:
  - a=32'h7FFF_FFFF + b=1 -> s=32'h8000_0000, ovf=1, co=0.
  - sub: a=5, b=7, ci=0 -> s=32'hFFFF_FFFE, co=0, ovf=0.
  - sub with borrow-in: a=10, b=3, ci=1 -> s=6, co=1.
- Streaming: 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, all matching the reference model.
- Backpressure: random out_ready (50%) and random in_valid -> no beat lost or duplicated; outputs stable while stalled; in_ready drops only when the pipeline is full and out_ready=0.
- Parameter sweep: (WIDTH,SEG_W) = (8,4), (16,8), (64,16) -> latency equals WIDTH/SEG_W and results match the model, including carry chains rippling through every segment (a=all ones, b=0, ci=1).
